// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor with configurable exponent and
// fraction widths, round-to-nearest-even, exception flags and a global
// valid/ready stall. Subnormal inputs and results flush to signed zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW   = MAN_W + 4;               // {1, frac, G, R, S}
    localparam int AW   = MAN_W + 5;               // SW plus carry
    localparam int LZW  = $clog2(MAN_W + 5);
    localparam int XW   = EXP_W + LZW + 2;         // signed working exponent
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic               c1_sa, c1_sb;
    logic [EXP_W-1:0]   c1_ea, c1_eb;
    logic [MAN_W-1:0]   c1_fa, c1_fb;
    logic               c1_a_zero, c1_b_zero, c1_a_inf, c1_b_inf;
    logic               c1_a_nan, c1_b_nan, c1_a_snan, c1_b_snan;
    logic [MAN_W:0]     c1_sig_a, c1_sig_b;
    logic [W-2:0]       c1_mag_a, c1_mag_b;
    logic               c1_swap;
    logic               c1_special;
    logic [W-1:0]       c1_res;
    logic [3:0]         c1_flags;

    // Decode operands, pick the larger magnitude and resolve special cases early
    always_comb begin
        c1_sa      = a[W-1];
        c1_sb      = b[W-1] ^ op;
        c1_ea      = a[W-2:MAN_W];
        c1_eb      = b[W-2:MAN_W];
        c1_fa      = a[MAN_W-1:0];
        c1_fb      = b[MAN_W-1:0];
        c1_a_zero  = (c1_ea == '0);
        c1_b_zero  = (c1_eb == '0);
        c1_a_inf   = (c1_ea == '1) && (c1_fa == '0);
        c1_b_inf   = (c1_eb == '1) && (c1_fb == '0);
        c1_a_nan   = (c1_ea == '1) && (c1_fa != '0);
        c1_b_nan   = (c1_eb == '1) && (c1_fb != '0);
        c1_a_snan  = c1_a_nan && !c1_fa[MAN_W-1];
        c1_b_snan  = c1_b_nan && !c1_fb[MAN_W-1];
        c1_sig_a   = c1_a_zero ? '0 : {1'b1, c1_fa};
        c1_sig_b   = c1_b_zero ? '0 : {1'b1, c1_fb};
        c1_mag_a   = {c1_ea, c1_a_zero ? {MAN_W{1'b0}} : c1_fa};
        c1_mag_b   = {c1_eb, c1_b_zero ? {MAN_W{1'b0}} : c1_fb};
        c1_swap    = (c1_mag_b > c1_mag_a);
        c1_special = 1'b1;
        c1_res     = '0;
        c1_flags   = '0;
        if (c1_a_nan || c1_b_nan) begin
            c1_res   = QNAN;
            c1_flags = {c1_a_snan | c1_b_snan, 3'b000};
        end else if (c1_a_inf && c1_b_inf && (c1_sa != c1_sb)) begin
            c1_res   = QNAN;
            c1_flags = 4'b1000;
        end else if (c1_a_inf) begin
            c1_res = {c1_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (c1_b_inf) begin
            c1_res = {c1_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (c1_a_zero && c1_b_zero) begin
            c1_res = {c1_sa & c1_sb, {(W-1){1'b0}}};
        end else begin
            c1_special = 1'b0;
        end
    end

    logic               s1_valid, s1_sign, s1_sub, s1_special;
    logic [EXP_W-1:0]   s1_exp, s1_d;
    logic [MAN_W:0]     s1_sig_big, s1_sig_small;
    logic [W-1:0]       s1_res;
    logic [3:0]         s1_flags;

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_sub       <= 1'b0;
            s1_special   <= 1'b0;
            s1_exp       <= '0;
            s1_d         <= '0;
            s1_sig_big   <= '0;
            s1_sig_small <= '0;
            s1_res       <= '0;
            s1_flags     <= '0;
        end else if (advance) begin
            s1_valid     <= in_valid;
            s1_sign      <= c1_swap ? c1_sb : c1_sa;
            s1_sub       <= c1_sa ^ c1_sb;
            s1_special   <= c1_special;
            s1_exp       <= c1_swap ? c1_eb : c1_ea;
            s1_d         <= c1_swap ? (c1_eb - c1_ea) : (c1_ea - c1_eb);
            s1_sig_big   <= c1_swap ? c1_sig_b : c1_sig_a;
            s1_sig_small <= c1_swap ? c1_sig_a : c1_sig_b;
            s1_res       <= c1_res;
            s1_flags     <= c1_flags;
        end
    end

    // ---------------- stage 2: align and add ----------------
    logic [SW-1:0] c2_small_ext, c2_mask, c2_aligned;
    logic [31:0]   c2_sh;
    logic          c2_sticky;
    logic [AW-1:0] c2_sum;

    // Right-shift the small significand with sticky collection, then add/subtract
    always_comb begin
        c2_small_ext = {s1_sig_small, 3'b000};
        c2_sh        = (32'(s1_d) >= 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(s1_d);
        c2_mask      = ~({SW{1'b1}} << c2_sh);
        c2_sticky    = |(c2_small_ext & c2_mask);
        c2_aligned   = (c2_small_ext >> c2_sh) | SW'(c2_sticky);
        if (s1_sub)
            c2_sum = {1'b0, s1_sig_big, 3'b000} - {1'b0, c2_aligned};
        else
            c2_sum = {1'b0, s1_sig_big, 3'b000} + {1'b0, c2_aligned};
    end

    logic               s2_valid, s2_sign, s2_special;
    logic [EXP_W-1:0]   s2_exp;
    logic [AW-1:0]      s2_sum;
    logic [W-1:0]       s2_res;
    logic [3:0]         s2_flags;

    // Stage 2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_special <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_res     <= '0;
            s2_flags   <= '0;
        end else if (advance) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_special <= s1_special;
            s2_exp     <= s1_exp;
            s2_sum     <= c2_sum;
            s2_res     <= s1_res;
            s2_flags   <= s1_flags;
        end
    end

    // ---------------- stage 3: normalise ----------------
    logic [LZW-1:0] c3_lz;
    logic           c3_found;
    logic [SW-1:0]  c3_norm;
    logic [XW-1:0]  c3_exp;

    // Leading-zero count and normalising shift; exponent kept in two's complement
    always_comb begin
        c3_lz    = LZW'(SW);
        c3_found = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!c3_found && s2_sum[SW-1-i]) begin
                c3_lz    = LZW'(i);
                c3_found = 1'b1;
            end
        end
        if (s2_sum[AW-1]) begin
            c3_norm    = s2_sum[AW-1:1];
            c3_norm[0] = s2_sum[1] | s2_sum[0];
            c3_exp     = XW'(s2_exp) + XW'(1);
        end else begin
            c3_norm = s2_sum[SW-1:0] << c3_lz;
            c3_exp  = XW'(s2_exp) - XW'(c3_lz);
        end
    end

    logic               s3_valid, s3_sign, s3_special, s3_zero;
    logic [XW-1:0]      s3_exp;
    logic [SW-1:0]      s3_sig;
    logic [W-1:0]       s3_res;
    logic [3:0]         s3_flags;

    // Stage 3 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid   <= 1'b0;
            s3_sign    <= 1'b0;
            s3_special <= 1'b0;
            s3_zero    <= 1'b0;
            s3_exp     <= '0;
            s3_sig     <= '0;
            s3_res     <= '0;
            s3_flags   <= '0;
        end else if (advance) begin
            s3_valid   <= s2_valid;
            s3_sign    <= s2_sign;
            s3_special <= s2_special;
            s3_zero    <= (s2_sum == '0);
            s3_exp     <= c3_exp;
            s3_sig     <= c3_norm;
            s3_res     <= s2_res;
            s3_flags   <= s2_flags;
        end
    end

    // ---------------- round and pack ----------------
    logic               c4_g, c4_r, c4_s, c4_rnd, c4_inexact, c4_ovf, c4_unf;
    logic [MAN_W+1:0]   c4_mant;
    logic [MAN_W-1:0]   c4_frac;
    logic [XW-1:0]      c4_exp;
    logic [W-1:0]       c4_res;
    logic [3:0]         c4_flags;

    // Round to nearest even, then apply specials, zero, overflow and underflow
    always_comb begin
        c4_g       = s3_sig[2];
        c4_r       = s3_sig[1];
        c4_s       = s3_sig[0];
        c4_rnd     = c4_g & (s3_sig[3] | c4_r | c4_s);
        c4_inexact = c4_g | c4_r | c4_s;
        c4_mant    = {1'b0, s3_sig[SW-1:3]} + (MAN_W+2)'(c4_rnd);
        if (c4_mant[MAN_W+1]) begin
            c4_exp  = s3_exp + XW'(1);
            c4_frac = c4_mant[MAN_W:1];
        end else begin
            c4_exp  = s3_exp;
            c4_frac = c4_mant[MAN_W-1:0];
        end
        c4_ovf = !c4_exp[XW-1] && (c4_exp >= XW'(EMAX));
        c4_unf = c4_exp[XW-1] || (c4_exp == '0);
        if (s3_special) begin
            c4_res   = s3_res;
            c4_flags = s3_flags;
        end else if (s3_zero) begin
            c4_res   = '0;
            c4_flags = '0;
        end else if (c4_ovf) begin
            c4_res   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            c4_flags = 4'b0101;
        end else if (c4_unf) begin
            c4_res   = {s3_sign, {(W-1){1'b0}}};
            c4_flags = 4'b0011;
        end else begin
            c4_res   = {s3_sign, c4_exp[EXP_W-1:0], c4_frac};
            c4_flags = {3'b000, c4_inexact};
        end
    end

    // Output register; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (advance) begin
            out_valid <= s3_valid;
            result    <= c4_res;
            flags     <= c4_flags;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: single and half precision instances,
// directed vectors, backpressure and mid-flight reset.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t q[$];
    sb_t hq[$];
    sb_t em, eh;
    int  checks = 0, failures = 0;
    int  pushes = 0, pops = 0, disc = 0;
    int  cyc = 0;

    fp_addsub_pipe u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Single precision monitor
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sp_unexpected_out result=%h flags=%b", result, flags);
            end else begin
                em = q[0];
                checks++;
                if (result !== em.res || flags !== em.fl) begin
                    failures++;
                    $display("FAIL sp_result got=%h/%b want=%h/%b", result, flags, em.res, em.fl);
                end
                if (!out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL sp_stall_in_ready got=%b want=0", in_ready);
                    end
                end else begin
                    void'(q.pop_front());
                    pops++;
                    if (em.lat) begin
                        checks++;
                        if (cyc != em.acc + 4) begin
                            failures++;
                            $display("FAIL sp_latency got=%0d want=%0d", cyc - em.acc - 1, 3);
                        end
                    end
                end
            end
        end
    end

    // Half precision monitor
    always @(negedge clk) begin
        if (rst_n && h_out_valid) begin
            if (hq.size() == 0) begin
                checks++; failures++;
                $display("FAIL hp_unexpected_out result=%h", h_result);
            end else begin
                eh = hq[0];
                checks++;
                if (h_result !== eh.res[15:0] || h_flags !== eh.fl) begin
                    failures++;
                    $display("FAIL hp_result got=%h/%b want=%h/%b", h_result, h_flags, eh.res[15:0], eh.fl);
                end
                if (h_out_ready) begin
                    void'(hq.pop_front());
                    pops++;
                    if (eh.lat) begin
                        checks++;
                        if (cyc != eh.acc + 4) begin
                            failures++;
                            $display("FAIL hp_latency got=%0d want=%0d", cyc - eh.acc - 1, 3);
                        end
                    end
                end
            end
        end
    end

    // Present one operation, wait (bounded) for acceptance, push its expectation
    task automatic issue(input bit hp, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] er, input logic [3:0] ef,
                         input bit lat);
        sb_t ent;
        bit  ok;
        ok = 1'b0;
        if (hp) begin
            h_a = av[15:0]; h_b = bv[15:0]; h_op = opv; h_in_valid = 1'b1;
        end else begin
            a = av; b = bv; op = opv; in_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((hp && h_in_ready) || (!hp && in_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout a=%h b=%h", av, bv);
        end else begin
            ent.res = er; ent.fl = ef; ent.acc = cyc; ent.lat = lat;
            if (hp) hq.push_back(ent);
            else    q.push_back(ent);
            pushes++;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        h_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0 && hq.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || hq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size() + hq.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%b/%b want=0/00000000/0000/1", out_valid, result, flags, in_ready);
        end
        checks++;
        if (h_out_valid !== 1'b0 || h_result !== 16'h0) begin
            failures++;
            $display("FAIL hp_reset_state got=%b/%h want=0/0000", h_out_valid, h_result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single precision vectors, back to back, latency checked
        issue(0, 32'h3F000000, 32'h3E800000, 0, 32'h3F400000, 4'b0000, 1);
        issue(0, 32'h3FC00000, 32'h40100000, 0, 32'h40700000, 4'b0000, 1);
        issue(0, 32'h40B80000, 32'h3EDC28F6, 0, 32'h40C5C28F, 4'b0001, 1);
        issue(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001, 1);
        issue(0, 32'h3F800000, 32'h34400000, 0, 32'h3F800002, 4'b0001, 1);
        issue(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'b0000, 1);
        issue(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 4'b1000, 1);
        issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101, 1);
        issue(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000, 1);
        issue(0, 32'h00C00000, 32'h00800000, 1, 32'h00000000, 4'b0011, 1);
        issue(0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000, 1);
        issue(0, 32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 4'b0000, 1);
        issue(0, 32'h7F800000, 32'h3F800000, 1, 32'h7F800000, 4'b0000, 1);
        issue(0, 32'h00000001, 32'h3F800000, 0, 32'h3F800000, 4'b0000, 1);
        issue(0, 32'h80000000, 32'h00000000, 0, 32'h00000000, 4'b0000, 1);
        drain();

        // Backpressure: five ops, out_ready held low 4 cycles once output appears
        fork
            begin
                issue(0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000, 0);
                issue(0, 32'h40000000, 32'h3F800000, 0, 32'h40400000, 4'b0000, 0);
                issue(0, 32'h40800000, 32'h40800000, 0, 32'h41000000, 4'b0000, 0);
                issue(0, 32'h3F800000, 32'h40000000, 1, 32'hBF800000, 4'b0000, 0);
                issue(0, 32'hC0000000, 32'h40000000, 1, 32'hC0800000, 4'b0000, 0);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                checks++;
                if (!seen) begin
                    failures++;
                    $display("FAIL bp_out_valid_timeout got=0 want=1");
                end
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with operations in flight
        issue(0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000, 0);
        issue(0, 32'h40000000, 32'h3F800000, 0, 32'h40400000, 4'b0000, 0);
        issue(0, 32'h40800000, 32'h40800000, 0, 32'h41000000, 4'b0000, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
            failures++;
            $display("FAIL midflight_reset got=%b/%h/%b want=0/00000000/0000", out_valid, result, flags);
        end
        disc += q.size();
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=0", out_valid);
        end

        // Half precision instance
        issue(1, 32'h3C00, 32'h3C00, 0, 32'h4000, 4'b0000, 1);
        issue(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 4'b0101, 1);
        issue(1, 32'h3C00, 32'h3C00, 1, 32'h0000, 4'b0000, 1);
        drain();

        checks++;
        if (pops != pushes - disc) begin
            failures++;
            $display("FAIL result_count got=%0d want=%0d", pops, pushes - disc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
